// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbiter: ALU opcodes, controller states and
// the opcode legality check used before a request is sent to the ALU.
package alu_pkg;

  localparam logic [3:0] NOOP  = 4'd0;
  localparam logic [3:0] ADD   = 4'd1;
  localparam logic [3:0] SUB   = 4'd2;
  localparam logic [3:0] MULT  = 4'd3;
  localparam logic [3:0] DIV   = 4'd4;
  localparam logic [3:0] AND   = 4'd5;
  localparam logic [3:0] OR    = 4'd6;
  localparam logic [3:0] XOR   = 4'd7;
  localparam logic [3:0] NOT   = 4'd8;
  localparam logic [3:0] RESET = 4'd15;

  // Widest operand the legality check can inspect; callers zero-extend into it.
  localparam int OPND_MAX_W = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic op_legal(input logic [3:0] op, input logic [OPND_MAX_W-1:0] in2);
    logic legal;
    case (op)
      NOOP, ADD, SUB, MULT, AND, OR, XOR, NOT: legal = 1'b1;
      DIV:     legal = (in2 != '0);
      RESET:   legal = 1'b0;
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant. The grant is combinational; the requester that
// won most recently loses a tie on the next arbitration.
module rr_arb2 (
  input  logic       clk_i,
  input  logic       clear_i,
  input  logic       en_i,
  input  logic [1:0] req_i,
  output logic [1:0] gnt_o,
  output logic       gntId_o
);

  logic lastGrant_q;
  logic lastGrant_d;

  always_comb begin
    gnt_o = 2'b00;
    if (en_i) begin
      unique case (req_i)
        2'b01:   gnt_o = 2'b01;
        2'b10:   gnt_o = 2'b10;
        2'b11:   gnt_o = lastGrant_q ? 2'b01 : 2'b10;
        default: gnt_o = 2'b00;
      endcase
    end
    gntId_o     = gnt_o[1];
    lastGrant_d = (|gnt_o) ? gnt_o[1] : lastGrant_q;
  end

  // Out of reset requester 1 counts as the last winner, so requester 0 wins the first tie.
  always_ff @(posedge clk_i or posedge clear_i) begin
    if (clear_i) lastGrant_q <= 1'b1;
    else         lastGrant_q <= lastGrant_d;
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between two requesters: arbitrates, holds the
// winner's operands on the ALU for ALU_LAT cycles and returns a tagged response.
module alu_arbiter
  import alu_pkg::*;
#(
  parameter int W       = 16,
  parameter int ALU_LAT = 1
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         req0_valid,
  output logic         req0_ready,
  input  logic [W-1:0] req0_in1,
  input  logic [W-1:0] req0_in2,
  input  logic [3:0]   req0_op,
  input  logic         req1_valid,
  output logic         req1_ready,
  input  logic [W-1:0] req1_in1,
  input  logic [W-1:0] req1_in2,
  input  logic [3:0]   req1_op,
  output logic [W-1:0] alu_in1,
  output logic [W-1:0] alu_in2,
  output logic [3:0]   alu_opcode,
  input  logic [W-1:0] alu_result,
  output logic         rsp_valid,
  output logic         rsp_id,
  output logic [W-1:0] rsp_data,
  output logic         rsp_err,
  output logic         busy
);

  localparam int               CNT_W    = $clog2(ALU_LAT + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(ALU_LAT - 1);

  state_e             state_q, state_d;
  logic [W-1:0]       in1_q, in1_d;
  logic [W-1:0]       in2_q, in2_d;
  logic [3:0]         op_q, op_d;
  logic               id_q, id_d;
  logic [CNT_W-1:0]   latCnt_q, latCnt_d;
  logic [W-1:0]       rspData_q, rspData_d;
  logic               rspErr_q, rspErr_d;

  logic [1:0]         gnt;
  logic               gntId;
  logic               accept;
  logic [W-1:0]       selIn1;
  logic [W-1:0]       selIn2;
  logic [3:0]         selOp;

  // Ready must stay low while clear is held, even though the state already reads IDLE.
  rr_arb2 u_arb (
    .clk_i   (clk),
    .clear_i (clear),
    .en_i    ((state_q == IDLE) && !clear),
    .req_i   ({req1_valid, req0_valid}),
    .gnt_o   (gnt),
    .gntId_o (gntId)
  );

  assign accept = |gnt;
  assign selIn1 = gntId ? req1_in1 : req0_in1;
  assign selIn2 = gntId ? req1_in2 : req0_in2;
  assign selOp  = gntId ? req1_op  : req0_op;

  always_ff @(posedge clk or posedge clear) begin
    if (clear) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d   = state_q;
    in1_d     = in1_q;
    in2_d     = in2_q;
    op_d      = op_q;
    id_d      = id_q;
    latCnt_d  = latCnt_q;
    rspData_d = rspData_q;
    rspErr_d  = rspErr_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          in1_d    = selIn1;
          in2_d    = selIn2;
          op_d     = selOp;
          id_d     = gntId;
          latCnt_d = '0;
          if (op_legal(selOp, OPND_MAX_W'(selIn2))) begin
            state_d = EXEC;
          end else begin
            state_d   = RESP;
            rspData_d = '0;
            rspErr_d  = 1'b1;
          end
        end
      end
      EXEC: begin
        if (latCnt_q == LAST_CNT) begin
          rspData_d = alu_result;
          rspErr_d  = 1'b0;
          state_d   = RESP;
        end else begin
          latCnt_d = latCnt_q + 1'b1;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      in1_q     <= '0;
      in2_q     <= '0;
      op_q      <= NOOP;
      id_q      <= 1'b0;
      latCnt_q  <= '0;
      rspData_q <= '0;
      rspErr_q  <= 1'b0;
    end else begin
      in1_q     <= in1_d;
      in2_q     <= in2_d;
      op_q      <= op_d;
      id_q      <= id_d;
      latCnt_q  <= latCnt_d;
      rspData_q <= rspData_d;
      rspErr_q  <= rspErr_d;
    end
  end

  // The ALU only sees real operands during EXEC; otherwise it idles on NOOP with zeros.
  always_comb begin
    req0_ready = gnt[0];
    req1_ready = gnt[1];
    busy       = (state_q != IDLE);
    alu_in1    = '0;
    alu_in2    = '0;
    alu_opcode = NOOP;
    rsp_valid  = 1'b0;
    rsp_id     = 1'b0;
    rsp_data   = '0;
    rsp_err    = 1'b0;
    unique case (state_q)
      EXEC: begin
        alu_in1    = in1_q;
        alu_in2    = in2_q;
        alu_opcode = op_q;
      end
      RESP: begin
        rsp_valid = 1'b1;
        rsp_id    = id_q;
        rsp_data  = rspData_q;
        rsp_err   = rspErr_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter: one instance with ALU_LAT=1 and one with
// ALU_LAT=3 share the requester inputs but have separate clears and ALUs.
module tb_alu_arbiter;
  import alu_pkg::*;

  logic        clk;
  logic        clear1;
  logic        clear3;
  logic        req0Valid, req1Valid;
  logic [15:0] req0In1, req0In2, req1In1, req1In2;
  logic [3:0]  req0Op, req1Op;

  logic        o1Ready0, o1Ready1, o1RspValid, o1RspId, o1RspErr, o1Busy;
  logic [15:0] o1AluIn1, o1AluIn2, o1AluResult, o1RspData;
  logic [3:0]  o1AluOpcode;
  logic        o3Ready0, o3Ready1, o3RspValid, o3RspId, o3RspErr, o3Busy;
  logic [15:0] o3AluIn1, o3AluIn2, o3AluResult, o3RspData;
  logic [3:0]  o3AluOpcode;

  int checkCount;
  int errorCount;

  function automatic logic [15:0] aluModel(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b);
    logic [31:0] prod;
    prod = 32'(a) * 32'(b);
    case (op)
      ADD:     return a + b;
      SUB:     return a - b;
      MULT:    return prod[15:0];
      DIV:     return (b == 16'd0) ? 16'd0 : a / b;
      AND:     return a & b;
      OR:      return a | b;
      XOR:     return a ^ b;
      NOT:     return ~a;
      default: return 16'd0;
    endcase
  endfunction

  assign o1AluResult = aluModel(o1AluOpcode, o1AluIn1, o1AluIn2);
  assign o3AluResult = aluModel(o3AluOpcode, o3AluIn1, o3AluIn2);

  alu_arbiter #(.W(16), .ALU_LAT(1)) dut1 (
    .clk(clk), .clear(clear1),
    .req0_valid(req0Valid), .req0_ready(o1Ready0), .req0_in1(req0In1), .req0_in2(req0In2), .req0_op(req0Op),
    .req1_valid(req1Valid), .req1_ready(o1Ready1), .req1_in1(req1In1), .req1_in2(req1In2), .req1_op(req1Op),
    .alu_in1(o1AluIn1), .alu_in2(o1AluIn2), .alu_opcode(o1AluOpcode), .alu_result(o1AluResult),
    .rsp_valid(o1RspValid), .rsp_id(o1RspId), .rsp_data(o1RspData), .rsp_err(o1RspErr), .busy(o1Busy)
  );

  alu_arbiter #(.W(16), .ALU_LAT(3)) dut3 (
    .clk(clk), .clear(clear3),
    .req0_valid(req0Valid), .req0_ready(o3Ready0), .req0_in1(req0In1), .req0_in2(req0In2), .req0_op(req0Op),
    .req1_valid(req1Valid), .req1_ready(o3Ready1), .req1_in1(req1In1), .req1_in2(req1In2), .req1_op(req1Op),
    .alu_in1(o3AluIn1), .alu_in2(o3AluIn2), .alu_opcode(o3AluOpcode), .alu_result(o3AluResult),
    .rsp_valid(o3RspValid), .rsp_id(o3RspId), .rsp_data(o3RspData), .rsp_err(o3RspErr), .busy(o3Busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checkCount++;
    if (got !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    clear1    = 1'b1;
    clear3    = 1'b1;
    req0Valid = 1'b1;
    req1Valid = 1'b0;
    tick();
    tick();
    #1;
    checkOutput("rst_ready", 32'({o1Ready1, o1Ready0}), 32'h0);
    checkOutput("rst_busy", 32'({o3Busy, o1Busy}), 32'h0);
    checkOutput("rst_rsp", 32'({o3RspValid, o1RspValid, o1RspId, o1RspErr}), 32'h0);
    checkOutput("rst_alu", 32'({o1AluOpcode, o1AluIn1, o1AluIn2}), 32'h0);
    req0Valid = 1'b0;
    clear1    = 1'b0;
    clear3    = 1'b0;
    tick();
  endtask

  // Drives a single request into dut1 and follows it to its response.
  task automatic applyStimulus(input logic id, input logic [3:0] op, input logic [15:0] a,
                               input logic [15:0] b, input logic [15:0] expData, input logic expErr);
    if (id) begin
      req1Valid = 1'b1; req1Op = op; req1In1 = a; req1In2 = b;
    end else begin
      req0Valid = 1'b1; req0Op = op; req0In1 = a; req0In2 = b;
    end
    #1;
    checkOutput("grant", 32'({o1Ready1, o1Ready0}), id ? 32'h2 : 32'h1);
    tick();
    req0Valid = 1'b0;
    req1Valid = 1'b0;
    #1;
    if (!expErr) begin
      checkOutput("exec_alu", 32'({o1AluOpcode, o1AluIn1, o1AluIn2}), 32'({op, a, b}));
      checkOutput("exec_busy", 32'({o1Busy, o1RspValid}), 32'h2);
      tick();
      #1;
    end
    checkOutput("rsp_flags", 32'({o1RspValid, o1RspId, o1RspErr}), 32'({1'b1, id, expErr}));
    checkOutput("rsp_data", 32'(o1RspData), 32'(expData));
    checkOutput("rsp_alu_idle", 32'({o1AluOpcode, o1AluIn1, o1AluIn2}), 32'h0);
    tick();
    #1;
    checkOutput("post_rsp", 32'({o1RspValid, o1Busy}), 32'h0);
  endtask

  initial begin
    int waitCnt;
    checkCount = 0;
    errorCount = 0;
    req0Valid = 1'b0; req1Valid = 1'b0;
    req0In1 = '0; req0In2 = '0; req0Op = NOOP;
    req1In1 = '0; req1In2 = '0; req1Op = NOOP;
    clear1 = 1'b0; clear3 = 1'b0;

    doReset();
    applyStimulus(1'b0, ADD, 16'h0001, 16'h0001, 16'h0002, 1'b0);

    // Both valid from reset: requester 0 goes first, requester 1 waits holding its request.
    doReset();
    req0Valid = 1'b1; req0Op = SUB; req0In1 = 16'h000F; req0In2 = 16'h0001;
    req1Valid = 1'b1; req1Op = AND; req1In1 = 16'hFF00; req1In2 = 16'h7E00;
    #1;
    checkOutput("tie_grant", 32'({o1Ready1, o1Ready0}), 32'h1);
    tick();
    req0Valid = 1'b0;
    #1;
    checkOutput("tie_exec0", 32'({o1AluOpcode, o1Ready1, o1Ready0, o1Busy}), 32'({SUB, 3'b001}));
    tick(); #1;
    checkOutput("tie_rsp0", 32'({o1RspValid, o1RspId, o1RspErr, o1RspData}), 32'({3'b100, 16'h000E}));
    tick(); #1;
    checkOutput("tie_grant1", 32'({o1Ready1, o1Ready0, o1Busy}), 32'h4);
    tick();
    req1Valid = 1'b0;
    #1;
    checkOutput("tie_exec1", 32'({o1AluOpcode, o1Busy}), 32'({AND, 1'b1}));
    tick(); #1;
    checkOutput("tie_rsp1", 32'({o1RspValid, o1RspId, o1RspErr, o1RspData}), 32'({3'b110, 16'h7E00}));
    tick(); #1;

    // Both held valid: six responses alternating 0,1,... every ALU_LAT+2 cycles.
    req0Valid = 1'b1; req0Op = ADD; req0In1 = 16'h0003; req0In2 = 16'h0004;
    req1Valid = 1'b1; req1Op = XOR; req1In1 = 16'h00FF; req1In2 = 16'h0F0F;
    for (int n = 0; n < 6; n++) begin
      waitCnt = 0;
      do begin
        tick();
        waitCnt++;
      end while (o1RspValid !== 1'b1 && waitCnt < 8);
      checkOutput("rr_spacing", 32'(waitCnt), (n == 0) ? 32'd2 : 32'd3);
      checkOutput("rr_id", 32'(o1RspId), 32'(n % 2));
      checkOutput("rr_data", 32'(o1RspData), (n % 2 == 0) ? 32'h0007 : 32'h0FF0);
    end
    req0Valid = 1'b0;
    req1Valid = 1'b0;
    tick(); #1;
    checkOutput("rr_idle", 32'({o1Busy, o1RspValid}), 32'h0);

    applyStimulus(1'b1, DIV, 16'h0008, 16'h0000, 16'h0000, 1'b1);
    applyStimulus(1'b0, 4'hF, 16'h0001, 16'h0002, 16'h0000, 1'b1);
    applyStimulus(1'b0, MULT, 16'h0002, 16'h0002, 16'h0004, 1'b0);
    applyStimulus(1'b0, MULT, 16'h8000, 16'h0002, 16'h0000, 1'b0);

    // ALU_LAT=3: clear in the second EXEC cycle aborts silently.
    doReset();
    req0Valid = 1'b1; req0Op = ADD; req0In1 = 16'h0005; req0In2 = 16'h0006;
    #1;
    checkOutput("l3_grant", 32'({o3Ready1, o3Ready0}), 32'h1);
    tick();
    req0Valid = 1'b0;
    #1;
    checkOutput("l3_exec1", 32'({o3AluOpcode, o3Busy}), 32'({ADD, 1'b1}));
    tick();
    clear3 = 1'b1;
    #1;
    checkOutput("l3_abort", 32'({o3Busy, o3RspValid, o3AluOpcode, o3AluIn1}), 32'h0);
    tick();
    clear3 = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkOutput("l3_no_rsp", 32'({o3RspValid, o3Busy}), 32'h0);
    end
    req1Valid = 1'b1; req1Op = SUB; req1In1 = 16'h0010; req1In2 = 16'h0003;
    #1;
    checkOutput("l3_grant1", 32'({o3Ready1, o3Ready0}), 32'h2);
    tick();
    req1Valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("l3_exec", 32'({o3AluOpcode, o3RspValid}), 32'({SUB, 1'b0}));
      tick();
    end
    #1;
    checkOutput("l3_rsp", 32'({o3RspValid, o3RspId, o3RspErr, o3RspData}), 32'({3'b110, 16'h000D}));
    tick(); #1;
    checkOutput("l3_idle", 32'({o3RspValid, o3Busy}), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
